// File: rtl/config_write_arbiter.sv
// N-source arbiter for the eFPGA configuration write port: per-source FIFOs, fixed-priority or
// round-robin grant, per-bitstream ownership lock, and minimum spacing between output strobes.
module config_write_arbiter #(
  parameter int unsigned NUM_SOURCES  = 2,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned FIFO_DEPTH   = 4,
  parameter int unsigned STROBE_GAP   = 1,
  parameter int unsigned LOCK_TIMEOUT = 64,
  parameter int unsigned ARB_MODE     = 0,
  localparam int unsigned OwnerW      = (NUM_SOURCES > 1) ? $clog2(NUM_SOURCES) : 1
) (
  input  logic                              clk_system_i,
  input  logic                              reset_n_i,
  input  logic                              enable_i,
  input  logic [NUM_SOURCES*DATA_WIDTH-1:0] src_data_i,
  input  logic [NUM_SOURCES-1:0]            src_strobe_i,
  input  logic [NUM_SOURCES-1:0]            src_active_i,
  output logic [DATA_WIDTH-1:0]             efpga_write_data_o,
  output logic                              efpga_write_strobe_o,
  output logic [OwnerW-1:0]                 owner_o,
  output logic                              owner_valid_o,
  output logic [NUM_SOURCES-1:0]            overflow_o,
  output logic                              busy_o
);

  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned IdleW = $clog2(LOCK_TIMEOUT + 1);

  typedef enum logic [0:0] {StIdle, StLocked} state_e;

  state_e                  state_q, state_d;
  logic [OwnerW-1:0]       owner_q, owner_d;
  logic [OwnerW-1:0]       rr_q, rr_d;
  logic [3:0]              gap_q, gap_d;
  logic [IdleW-1:0]        idle_q, idle_d;
  logic                    strobe_q;
  logic [DATA_WIDTH-1:0]   data_q;

  logic                    pop_en;
  logic [OwnerW-1:0]       pop_src;
  logic [OwnerW-1:0]       winner;
  logic [NUM_SOURCES-1:0]  nonempty;
  logic [DATA_WIDTH-1:0]   head [NUM_SOURCES];

  // Per-source FIFO; a full FIFO still accepts a push when it is popped in the same cycle.
  for (genvar k = 0; k < NUM_SOURCES; k++) begin : g_src
    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]       wr_q, rd_q;
    logic [CntW-1:0]       cnt_q;
    logic                  ovf_q;
    logic                  full, pop_k, push_ok;

    assign full    = (cnt_q == CntW'(FIFO_DEPTH));
    assign pop_k   = pop_en && (pop_src == OwnerW'(k));
    assign push_ok = src_strobe_i[k] && (!full || pop_k);

    always_ff @(posedge clk_system_i) begin
      if (!reset_n_i) begin
        wr_q  <= '0;
        rd_q  <= '0;
        cnt_q <= '0;
        ovf_q <= 1'b0;
      end else begin
        if (push_ok) wr_q <= wr_q + PtrW'(1);
        if (pop_k)   rd_q <= rd_q + PtrW'(1);
        if (push_ok && !pop_k) begin
          cnt_q <= cnt_q + CntW'(1);
        end else if (!push_ok && pop_k) begin
          cnt_q <= cnt_q - CntW'(1);
        end
        if (src_strobe_i[k] && !push_ok) ovf_q <= 1'b1;
      end
    end

    always_ff @(posedge clk_system_i) begin
      if (push_ok) mem_q[wr_q] <= src_data_i[k*DATA_WIDTH +: DATA_WIDTH];
    end

    assign nonempty[k]   = (cnt_q != '0);
    assign head[k]       = mem_q[rd_q];
    assign overflow_o[k] = ovf_q;
  end

  // Winner selection: lowest non-empty index, or first non-empty at/after the rr pointer.
  always_comb begin
    int   idx;
    logic found;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    if (ARB_MODE == 0) begin
      for (int i = int'(NUM_SOURCES) - 1; i >= 0; i--) begin
        if (nonempty[i]) winner = OwnerW'(i);
      end
    end else begin
      for (int i = 0; i < int'(NUM_SOURCES); i++) begin
        idx = int'(rr_q) + i;
        if (idx >= int'(NUM_SOURCES)) idx = idx - int'(NUM_SOURCES);
        if (!found && nonempty[OwnerW'(idx)]) begin
          winner = OwnerW'(idx);
          found  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_system_i) begin
    if (!reset_n_i) begin
      state_q <= StIdle;
      owner_q <= '0;
      rr_q    <= '0;
      gap_q   <= '0;
      idle_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      gap_q   <= gap_d;
      idle_q  <= idle_d;
    end
  end

  // With enable low everything freezes; only the already-registered strobe completes.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    gap_d   = gap_q;
    idle_d  = idle_q;
    pop_en  = 1'b0;
    pop_src = owner_q;
    if (enable_i) begin
      if (gap_q != 4'd0) gap_d = gap_q - 4'd1;
      unique case (state_q)
        StIdle: begin
          if (|nonempty) begin
            state_d = StLocked;
            owner_d = winner;
            pop_src = winner;
            idle_d  = '0;
            pop_en  = (gap_q == 4'd0);
          end
        end
        StLocked: begin
          if (nonempty[owner_q]) begin
            if (gap_q == 4'd0) begin
              pop_en = 1'b1;
              idle_d = '0;
            end
          end else if (!src_active_i[owner_q] || idle_q == IdleW'(LOCK_TIMEOUT)) begin
            state_d = StIdle;
            rr_d    = (owner_q == OwnerW'(NUM_SOURCES - 1)) ? '0 : owner_q + OwnerW'(1);
            idle_d  = '0;
          end else if (idle_q != IdleW'(LOCK_TIMEOUT)) begin
            idle_d = idle_q + IdleW'(1);
          end
        end
        default: state_d = StIdle;
      endcase
      if (pop_en) gap_d = 4'(STROBE_GAP);
    end
  end

  always_comb begin
    owner_valid_o = (state_q == StLocked);
    busy_o        = owner_valid_o || (|nonempty);
  end

  always_ff @(posedge clk_system_i) begin
    if (!reset_n_i) begin
      strobe_q <= 1'b0;
      data_q   <= '0;
    end else begin
      strobe_q <= pop_en;
      if (pop_en) data_q <= head[pop_src];
    end
  end

  assign efpga_write_data_o   = data_q;
  assign efpga_write_strobe_o = strobe_q;
  assign owner_o              = owner_q;

endmodule

// File: doc/config_write_arbiter.md
Name: config_write_arbiter

Overview:
- Parametrised N-source arbiter for the eFPGA configuration write port (SelfWriteData/SelfWriteStrobe).
- Generalises the fixed two-way JTAG/USB select to NUM_SOURCES writers, with per-source buffering, fixed-priority or round-robin arbitration, and per-bitstream ownership locking.
- Enforces a minimum spacing between output strobes.
- Sits between the config writers (USB controller, JTAG TAP, future loaders) and eFPGA_top.

Parameters:
- NUM_SOURCES, 2: number of writer channels (1..8).
- DATA_WIDTH, 32: config word width.
- FIFO_DEPTH, 4: words buffered per source; power of two, >= 2.
- STROBE_GAP, 1: minimum idle cycles between consecutive output strobes (0..15).
- LOCK_TIMEOUT, 64: owner-idle cycles before the lock is released (>= 1).
- ARB_MODE, 0: 0 = fixed priority, lowest index wins; 1 = round-robin.

Ports:
- clk_system_i  in  1  system clock; all logic on the rising edge.
- reset_n_i  in  1  synchronous, active-low reset.
- enable_i  in  1  arbitration/pop enable; pushes are unaffected.
- src_data_i  in  NUM_SOURCES*DATA_WIDTH  source words; source k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- src_strobe_i  in  NUM_SOURCES  one-cycle write strobe per source.
- src_active_i  in  NUM_SOURCES  source k is mid-bitstream and holds its lock.
- efpga_write_data_o  out  DATA_WIDTH  registered config word.
- efpga_write_strobe_o  out  1  one-cycle pulse; data is valid in the same cycle.
- owner_o  out  max(1,$clog2(NUM_SOURCES))  index of the current lock holder.
- owner_valid_o  out  1  lock held.
- overflow_o  out  NUM_SOURCES  sticky per-source drop flag.
- busy_o  out  1  owner_valid_o OR any FIFO non-empty.

Behaviour:
- Reset (reset_n_i=0 at an edge):
  - All FIFOs emptied; state IDLE; round-robin pointer 0; gap counter 0; idle counter 0.
  - All outputs 0, including data.
  - Reset mid-operation discards buffered words; no strobe is emitted in the cycle after reset.
- Push:
  - src_strobe_i[k]=1 writes word k into FIFO k at that edge.
  - If FIFO k is full and not popped in the same cycle, the word is dropped and overflow_o[k] is set. The flag clears only on reset.
  - Push and pop on a full FIFO in the same cycle: both succeed, no overflow.
- Gap counter:
  - Loaded with STROBE_GAP on every output strobe; decrements to 0.
  - A pop is allowed only when the counter is 0.
- State IDLE:
  - If enable_i=1 and any FIFO is non-empty, select a winner.
    - ARB_MODE 0: lowest index with a non-empty FIFO.
    - ARB_MODE 1: first non-empty index at or after the pointer, with wrap-around.
  - Register the winner as owner, go to LOCKED, and pop its head word in the same cycle if the gap counter is 0.
  - src_active_i alone, with an empty FIFO, does not request a grant.
- State LOCKED:
  - If enable_i=1, FIFO[owner] non-empty and gap counter 0: pop, register the word into efpga_write_data_o, and pulse the strobe the next cycle. Idle counter resets to 0.
  - Otherwise the idle counter increments while FIFO[owner] is empty; it saturates.
  - Release to IDLE when FIFO[owner] is empty and either src_active_i[owner]=0 or the idle counter equals LOCK_TIMEOUT.
  - On release: owner_valid_o goes to 0; the round-robin pointer becomes owner+1 (mod NUM_SOURCES); idle counter cleared.
  - Non-owner words stay buffered (or overflow) while the lock is held. No interleaving of sources is permitted.
- Latency: a strobe at edge N into an empty, idle, gap-free arbiter gives efpga_write_strobe_o=1 in the cycle after edge N+1, i.e. 2 cycles.
- Throughput: one word per STROBE_GAP+1 cycles.
- enable_i=0:
  - No grant, no pop; the lock and counters are held; the idle counter is frozen.
  - The strobe already in flight still completes.
- owner_o holds its last value when owner_valid_o=0 (0 after reset).

Test Plan:
- Single source k=0, STROBE_GAP=1: push 0xA5A5_0001..0004 on consecutive cycles → four strobes on alternate cycles, in order, first strobe 2 cycles after the first push; owner_o=0, owner_valid_o=1.
- ARB_MODE=0: source 1 pushes 0x11, then one cycle later source 0 pushes 0x00, with src_active_i[1]=1 → 0x11 emitted first. Source 0 waits until src_active_i[1] drops, then 0x00 emits and owner_o=0.
- ARB_MODE=1, NUM_SOURCES=3: all sources push one word each per bitstream with active pulsed → grant order 0,1,2,0; pointer wrap verified.
- Overflow, FIFO_DEPTH=4, enable_i=0: push 5 words to source 1 → overflow_o=0b10; after enable_i=1 exactly 4 words emit; flag persists until reset.
- Lock timeout, LOCK_TIMEOUT=8: owner keeps src_active_i=1 with an empty FIFO; source 1 has a pending word → release after 8 idle cycles, then source 1 is granted.
- Reset mid-stream: assert reset_n_i=0 for one cycle with 3 words buffered → all outputs 0 next cycle; no stale strobes afterwards; overflow cleared.
